// File: rtl/biquad8_stim_pkg.sv
// Shared types and lane packing helpers for the biquad8 stimulus generator.
// A packed beat holds NSAMP lanes of 16 bits; each 12-bit sample sits in the
// upper bits of its lane and the low nibble is always zero.
package biquad8_stim_pkg;

    localparam int NSAMP  = 8;
    localparam int NBITS  = 12;
    localparam int LANE_W = 16;
    localparam int PAD_W  = LANE_W - NBITS;
    localparam int DATA_W = NSAMP * LANE_W;
    localparam int RAW_W  = NSAMP * NBITS;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_STEP    = 2'd2,
        MODE_GATE    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    // Place each 12-bit sample into the upper bits of its 16-bit lane.
    function automatic logic [DATA_W-1:0] pack_lanes(input logic [RAW_W-1:0] raw);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < NSAMP; i++) begin
            res[LANE_W*i+PAD_W +: NBITS] = raw[NBITS*i +: NBITS];
        end
        return res;
    endfunction

    // Extract the 12-bit samples from a packed beat, discarding the low nibbles.
    function automatic logic [RAW_W-1:0] unpack_lanes(input logic [DATA_W-1:0] beat);
        logic [RAW_W-1:0] res;
        res = '0;
        for (int i = 0; i < NSAMP; i++) begin
            res[NBITS*i +: NBITS] = beat[LANE_W*i+PAD_W +: NBITS];
        end
        return res;
    endfunction

endpackage

// File: rtl/biquad8_stimulus_gen.sv
// Triggered test-stimulus source in front of the biquad8 filter input.
// A rising capture_i edge in IDLE starts delay -> window -> holdoff; during the
// window an impulse, a step or gated ADC data is emitted, otherwise the ADC
// stream (PASS) or zeros are forwarded. All outputs are registered.
module biquad8_stimulus_gen #(
    parameter int NSAMP    = 8,
    parameter int NBITS    = 12,
    parameter int DLY_BITS = 8,
    parameter int LEN_BITS = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  capture_i,
    input  logic [1:0]            mode_i,
    input  logic [DLY_BITS-1:0]   delay_i,
    input  logic [LEN_BITS-1:0]   length_i,
    input  logic [NBITS-1:0]      amplitude_i,
    input  logic [2:0]            position_i,
    input  logic [NSAMP*16-1:0]   adc_tdata,
    input  logic                  adc_tvalid,
    output logic                  adc_tready,
    output logic [NSAMP*16-1:0]   out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  armed_o,
    output logic                  busy_o,
    output logic                  done_o
);
    import biquad8_stim_pkg::*;

    localparam int BEAT_W    = NSAMP * 16;
    localparam int SAMP_BITS = NSAMP * NBITS;

    state_e                state_r, state_nxt_s;
    logic [DLY_BITS-1:0]   dly_cnt_r, dly_cnt_nxt_s;
    logic [LEN_BITS-1:0]   beat_r, beat_nxt_s;
    logic [LEN_BITS-1:0]   len_m1_r, len_m1_s;
    mode_e                 mode_r;
    logic [NBITS-1:0]      amp_r;
    logic [2:0]            pos_r;
    logic                  cap_hist_r;
    logic                  trigger_s;
    logic                  done_nxt_s;
    logic [SAMP_BITS-1:0]  adc_raw_s;
    logic [SAMP_BITS-1:0]  lanes_s;
    logic [BEAT_W-1:0]     data_nxt_s;
    logic                  unused_s;

    // The source never stalls and the filter side cannot back-pressure it.
    assign adc_tready = 1'b1;
    assign unused_s   = out_tready;

    assign trigger_s = (state_r == ST_IDLE) && capture_i && !cap_hist_r;

    // Window length of zero behaves as a single beat.
    always_comb begin
        len_m1_s = '0;
        if (length_i == '0) begin
            len_m1_s = '0;
        end else begin
            len_m1_s = length_i - LEN_BITS'(1);
        end
    end

    // Next-state logic for the delay/window/holdoff sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        dly_cnt_nxt_s = dly_cnt_r;
        beat_nxt_s    = beat_r;
        done_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    beat_nxt_s = '0;
                    if (delay_i != '0) begin
                        state_nxt_s   = ST_DELAY;
                        dly_cnt_nxt_s = delay_i - DLY_BITS'(1);
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (dly_cnt_r == '0) begin
                    state_nxt_s = ST_ACTIVE;
                    beat_nxt_s  = '0;
                end else begin
                    dly_cnt_nxt_s = dly_cnt_r - DLY_BITS'(1);
                end
            end
            ST_ACTIVE: begin
                if (beat_r == len_m1_r) begin
                    state_nxt_s = ST_HOLDOFF;
                    done_nxt_s  = 1'b1;
                end else begin
                    beat_nxt_s = beat_r + LEN_BITS'(1);
                end
            end
            ST_HOLDOFF: begin
                if (!capture_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, counters, capture history and latched configuration.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            dly_cnt_r  <= '0;
            beat_r     <= '0;
            len_m1_r   <= '0;
            mode_r     <= MODE_PASS;
            amp_r      <= '0;
            pos_r      <= 3'd0;
            cap_hist_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            dly_cnt_r  <= dly_cnt_nxt_s;
            beat_r     <= beat_nxt_s;
            cap_hist_r <= capture_i;
            if (trigger_s) begin
                len_m1_r <= len_m1_s;
                mode_r   <= mode_e'(mode_i);
                amp_r    <= amplitude_i;
                pos_r    <= position_i;
            end
        end
    end

    // An invalid ADC beat is treated as all-zero samples.
    always_comb begin
        adc_raw_s = '0;
        if (adc_tvalid) begin
            adc_raw_s = unpack_lanes(adc_tdata);
        end else begin
            adc_raw_s = '0;
        end
    end

    // Lane pattern mux: window pattern from latched config, else live PASS/zero.
    always_comb begin
        lanes_s = '0;
        if (state_r == ST_ACTIVE) begin
            case (mode_r)
                MODE_IMPULSE: begin
                    for (int i = 0; i < NSAMP; i++) begin
                        if ((beat_r == '0) && (3'(i) == pos_r)) begin
                            lanes_s[NBITS*i +: NBITS] = amp_r;
                        end else begin
                            lanes_s[NBITS*i +: NBITS] = '0;
                        end
                    end
                end
                MODE_STEP: begin
                    for (int i = 0; i < NSAMP; i++) begin
                        if ((beat_r != '0) || (3'(i) >= pos_r)) begin
                            lanes_s[NBITS*i +: NBITS] = amp_r;
                        end else begin
                            lanes_s[NBITS*i +: NBITS] = '0;
                        end
                    end
                end
                default: begin
                    lanes_s = adc_raw_s;
                end
            endcase
        end else begin
            if (mode_i == MODE_PASS) begin
                lanes_s = adc_raw_s;
            end else begin
                lanes_s = '0;
            end
        end
        data_nxt_s = pack_lanes(lanes_s);
    end

    // Registered stream and status outputs, one beat behind the sequencer.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            armed_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            out_tdata  <= data_nxt_s;
            out_tvalid <= 1'b1;
            armed_o    <= (state_r == ST_IDLE);
            busy_o     <= (state_r == ST_DELAY) || (state_r == ST_ACTIVE);
            done_o     <= done_nxt_s;
        end
    end

endmodule
